// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle slave backed by a register-array memory, with programmable
// wait states, error termination for out-of-range words and acked-transfer counters.
module wb_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int AW         = 30,
    parameter int CW         = 16
) (
    input  logic          sys_clk,
    input  logic          RESETN,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_dat_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [31:0]   wb_dat_o,
    input  logic [3:0]    cfg_wait_i,
    output logic [CW-1:0] wr_cnt_o,
    output logic [CW-1:0] rd_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     dat_q, dat_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdat_q, rdat_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;

    logic [31:0]     mem_q [DEPTH];

    // Transfer being terminated: live bus inputs for a zero-wait accept, latched copy otherwise.
    logic                  term;
    logic [AW-1:0]         x_addr;
    logic                  x_we;
    logic [3:0]            x_sel;
    logic [31:0]           x_dat;
    logic                  in_range;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdat_d   = rdat_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        term     = 1'b0;
        x_addr   = addr_q;
        x_we     = we_q;
        x_sel    = sel_q;
        x_dat    = dat_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_d = wb_addr_i;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    dat_d  = wb_dat_i;
                    wcnt_d = cfg_wait_i;
                    x_addr = wb_addr_i;
                    x_we   = wb_we_i;
                    x_sel  = wb_sel_i;
                    x_dat  = wb_dat_i;
                    if (cfg_wait_i == 4'd0) begin
                        term    = 1'b1;
                        state_d = TERM;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    wcnt_d  = 4'd0;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        term    = 1'b1;
                        state_d = TERM;
                    end
                end
            end
            TERM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_range = (x_addr[AW-1:DEPTH_LOG2] == '0);
        mem_idx  = x_addr[DEPTH_LOG2-1:0];
        mem_we   = term && in_range && x_we;

        if (term) begin
            if (in_range) begin
                ack_d = 1'b1;
                if (x_we) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                end else begin
                    rdat_d   = mem_q[mem_idx];
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end else begin
                err_d  = 1'b1;
                rdat_d = 32'd0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            wcnt_q   <= 4'd0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            dat_q    <= 32'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= 32'd0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive a bus reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (x_sel[b]) mem_q[mem_idx][8*b +: 8] <= x_dat[8*b +: 8];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = rdat_q;
    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder: wait states, byte lanes, range errors,
// abort, asynchronous reset, back-to-back throughput and counter wrap.
module tb_wb_sram_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int AW         = 30;
    localparam int CW         = 4;

    logic          sys_clk = 1'b0;
    logic          RESETN  = 1'b0;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i  = 1'b0;
    logic [AW-1:0] wb_addr_i = '0;
    logic [3:0]    wb_sel_i  = 4'd0;
    logic [31:0]   wb_dat_i  = 32'd0;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    cfg_wait_i = 4'd0;
    logic [CW-1:0] wr_cnt_o;
    logic [CW-1:0] rd_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int last_samp = 0;
    int gap = 0;

    wb_sram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .AW(AW), .CW(CW)) dut (
        .sys_clk(sys_clk), .RESETN(RESETN),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
        .cfg_wait_i(cfg_wait_i), .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; inputs are scrambled right after acceptance to prove they were latched.
    task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [3:0] w,
                        output logic ack_seen, output logic err_seen,
                        output int lat, output logic [31:0] rd);
        @(negedge sys_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_addr_i = a; wb_sel_i = s; wb_dat_i = d; cfg_wait_i = w;
        @(posedge sys_clk); #1;
        gap = cyc_n - last_samp;
        last_samp = cyc_n;
        lat = 0;
        wb_addr_i = a ^ 30'h155; wb_dat_i = ~d; cfg_wait_i = 4'd0;
        while (!wb_ack_o && !wb_err_o && lat < 40) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        ack_seen = wb_ack_o;
        err_seen = wb_err_o;
        rd = wb_dat_o;
        @(negedge sys_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge sys_clk); #1;
        chk("pulse_width", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    endtask

    task automatic wr_ok(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic [3:0] w);
        logic ak, er; int lt; logic [31:0] rd;
        xfer(1'b1, a, s, d, w, ak, er, lt, rd);
        chk("wr_ack", {31'd0, ak}, 32'd1);
        chk("wr_err", {31'd0, er}, 32'd0);
        chk("wr_latency", lt, {28'd0, w});
    endtask

    task automatic rd_chk(input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] exp);
        logic ak, er; int lt; logic [31:0] rd;
        xfer(1'b0, a, 4'h0, 32'd0, w, ak, er, lt, rd);
        chk("rd_ack", {31'd0, ak}, 32'd1);
        chk("rd_err", {31'd0, er}, 32'd0);
        chk("rd_latency", lt, {28'd0, w});
        chk("rd_data", rd, exp);
    endtask

    task automatic err_chk(input logic we, input logic [AW-1:0] a, input logic [3:0] w);
        logic ak, er; int lt; logic [31:0] rd;
        xfer(we, a, 4'hF, 32'h5555_AAAA, w, ak, er, lt, rd);
        chk("oor_ack", {31'd0, ak}, 32'd0);
        chk("oor_err", {31'd0, er}, 32'd1);
        chk("oor_latency", lt, {28'd0, w});
        chk("oor_dat_zero", rd, 32'd0);
    endtask

    initial begin
        logic seen;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_err", {31'd0, wb_err_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_wr_cnt", {28'd0, wr_cnt_o}, 32'd0);
        chk("rst_rd_cnt", {28'd0, rd_cnt_o}, 32'd0);
        @(negedge sys_clk);
        RESETN = 1'b1;

        // Zero-wait write then read
        wr_ok(30'h010, 4'hF, 32'hA5A5_1234, 4'd0);
        rd_chk(30'h010, 4'd0, 32'hA5A5_1234);
        chk("w0_wr_cnt", {28'd0, wr_cnt_o}, 32'd1);
        chk("w0_rd_cnt", {28'd0, rd_cnt_o}, 32'd1);

        // Byte lanes
        wr_ok(30'h020, 4'hF, 32'hFFFF_FFFF, 4'd0);
        wr_ok(30'h020, 4'b0101, 32'h1122_3344, 4'd0);
        rd_chk(30'h020, 4'd0, 32'hFF22_FF44);

        // Three wait states; cfg_wait_i is cleared mid-wait inside xfer
        rd_chk(30'h020, 4'd3, 32'hFF22_FF44);
        chk("w3_rd_cnt", {28'd0, rd_cnt_o}, 32'd3);

        // Out of range write aliases onto word 0 but must not touch it
        wr_ok(30'h000, 4'hF, 32'hDEAD_BEEF, 4'd0);
        rd_chk(30'h010, 4'd0, 32'hA5A5_1234);
        err_chk(1'b1, 30'h400, 4'd0);
        chk("oor_wr_cnt", {28'd0, wr_cnt_o}, 32'd4);
        rd_chk(30'h000, 4'd0, 32'hDEAD_BEEF);
        err_chk(1'b0, 30'h3FFF_FFFF, 4'd2);
        chk("oor_rd_cnt", {28'd0, rd_cnt_o}, 32'd5);

        // Abort: cyc dropped during the wait
        wr_ok(30'h030, 4'hF, 32'h0BAD_F00D, 4'd0);
        @(negedge sys_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_addr_i = 30'h030; wb_sel_i = 4'hF; wb_dat_i = 32'h1234_5678; cfg_wait_i = 4'd5;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge sys_clk); #1;
            if (wb_ack_o || wb_err_o) seen = 1'b1;
        end
        chk("abort_no_term", {31'd0, seen}, 32'd0);
        chk("abort_wr_cnt", {28'd0, wr_cnt_o}, 32'd5);
        rd_chk(30'h030, 4'd0, 32'h0BAD_F00D);

        // Asynchronous reset during a wait
        @(negedge sys_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_addr_i = 30'h030; wb_sel_i = 4'hF; wb_dat_i = 32'h55AA_55AA; cfg_wait_i = 4'd5;
        repeat (2) @(posedge sys_clk);
        #2;
        RESETN = 1'b0;
        #1;
        chk("arst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("arst_err", {31'd0, wb_err_o}, 32'd0);
        chk("arst_dat", wb_dat_o, 32'd0);
        chk("arst_wr_cnt", {28'd0, wr_cnt_o}, 32'd0);
        chk("arst_rd_cnt", {28'd0, rd_cnt_o}, 32'd0);
        @(negedge sys_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge sys_clk);
        RESETN = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge sys_clk); #1;
            if (wb_ack_o || wb_err_o) seen = 1'b1;
        end
        chk("arst_no_term", {31'd0, seen}, 32'd0);
        rd_chk(30'h030, 4'd0, 32'h0BAD_F00D);
        chk("arst_rd_cnt_after", {28'd0, rd_cnt_o}, 32'd1);

        // Back-to-back at two cycles per transfer
        for (int i = 0; i < 4; i++) begin
            wr_ok(30'h100 + 30'(i), 4'hF, 32'hC0DE_0000 + 32'(i * 32'h0101), 4'd0);
            if (i > 0) chk("b2b_wr_gap", gap, 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            rd_chk(30'h100 + 30'(i), 4'd0, 32'hC0DE_0000 + 32'(i * 32'h0101));
            chk("b2b_rd_gap", gap, 32'd2);
        end
        chk("b2b_wr_cnt", {28'd0, wr_cnt_o}, 32'd4);
        chk("b2b_rd_cnt", {28'd0, rd_cnt_o}, 32'd5);

        // Write counter wraps modulo 2^CW
        for (int i = 0; i < 12; i++) begin
            wr_ok(30'h200 + 30'(i), 4'hF, 32'(i), 4'd0);
        end
        chk("wrap_wr_cnt", {28'd0, wr_cnt_o}, 32'd0);
        wr_ok(30'h20C, 4'hF, 32'h0000_0077, 4'd1);
        chk("wrap_wr_cnt_next", {28'd0, wr_cnt_o}, 32'd1);
        rd_chk(30'h20C, 4'd1, 32'h0000_0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
